nibble_serial_sub_ctrl: RTL and testbench

Sequencing controller for the team's 4-bit adder-based subtractor (A + ~B + 1). It subtracts two wide unsigned operands one nibble per clock on a single 4-bit adder slice, LSB nibble first, chaining the carry between cycles. Operands enter through a valid/ready request channel, and results leave through a valid/ready response channel. The block sits between a requester (ALU sequencer or test driver) and the shared subtractor datapath.

---
 rtl/nibble_serial_sub_ctrl.sv | 145 ++++++++++++++
 tb/tb_nibble_serial_sub_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_sub_ctrl.sv
// nibble_serial_sub_ctrl
//
// Sequences a wide unsigned subtraction a - b through one 4-bit adder slice.
// The slice computes a + ~b + carry one nibble per clock, LSB nibble first.
// The carry starts at 1 and is chained from cycle to cycle.
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready.
// The producer holds valid, and the data it qualifies, stable until that edge.
// The consumer may raise or lower ready at any time.
//   start channel: start_valid / start_ready, payload a, b
//   diff channel : diff_valid  / diff_ready,  payload diff, borrow, zero, ovf
//
// Ports
//   clk          single clock, rising edge
//   rst_n        asynchronous active-low reset
//   start_valid  requester presents operands
//   start_ready  high in IDLE (and therefore during reset)
//   a, b         W-bit minuend / subtrahend, sampled on the start handshake
//   diff_valid   high in DONE
//   diff_ready   consumer accepts the result
//   diff         a - b modulo 2^W
//   borrow       a < b unsigned (inverse of the final carry)
//   zero         diff == 0
//   ovf          signed overflow of the subtraction
//   state_dbg    current FSM state (IDLE=0, RUN=1, DONE=2) for observation
module nibble_serial_sub_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_valid,
  output logic                 start_ready,
  input  logic [4*NIBBLES-1:0] a,
  input  logic [4*NIBBLES-1:0] b,
  output logic                 diff_valid,
  input  logic                 diff_ready,
  output logic [4*NIBBLES-1:0] diff,
  output logic                 borrow,
  output logic                 zero,
  output logic                 ovf,
  output logic [1:0]           state_dbg
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   a_q, b_q;
  logic [W-1:0]   shadow_q;   // partial result; diff only sees it when complete
  logic [IW-1:0]  idx_q;
  logic           carry_q;

  logic [3:0]     a_nib, b_nib;
  logic [4:0]     sum;
  logic [W-1:0]   result;     // shadow with the current slice merged in
  logic           last;

  // Slice selection and the one shared 4-bit adder.
  always_comb begin
    a_nib = '0;
    b_nib = '0;
    for (int n = 0; n < NIBBLES; n++) begin
      if (idx_q == IW'(n)) begin
        a_nib = a_q[n*4 +: 4];
        b_nib = b_q[n*4 +: 4];
      end
    end
    sum    = {1'b0, a_nib} + {1'b0, ~b_nib} + {4'b0000, carry_q};
    result = shadow_q;
    for (int n = 0; n < NIBBLES; n++) begin
      if (idx_q == IW'(n)) begin
        result[n*4 +: 4] = sum[3:0];
      end
    end
    last = (idx_q == IW'(NIBBLES - 1));
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_valid)             state_d = RUN;
      RUN:     if (last)                    state_d = DONE;
      DONE:    if (diff_ready)              state_d = IDLE;
      default:                              state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      shadow_q <= '0;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      diff     <= '0;
      borrow   <= 1'b0;
      zero     <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_valid) begin
            a_q     <= a;
            b_q     <= b;
            idx_q   <= '0;
            carry_q <= 1'b1;   // the +1 of the two's-complement subtrahend
          end
        end
        RUN: begin
          shadow_q <= result;
          carry_q  <= sum[4];
          idx_q    <= idx_q + 1'b1;
          if (last) begin
            diff   <= result;
            borrow <= ~sum[4];
            zero   <= (result == '0);
            ovf    <= (a_q[W-1] != b_q[W-1]) && (result[W-1] != a_q[W-1]);
          end
        end
        default: ;
      endcase
    end
  end

  assign start_ready = (state_q == IDLE);
  assign diff_valid  = (state_q == DONE);
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_nibble_serial_sub_ctrl.sv
// tb_nibble_serial_sub_ctrl
//
// Two instances: NIBBLES=4 (16-bit) and NIBBLES=1 (4-bit). sel picks which
// one the driver talks to; both share the a/b/diff_ready/reset stimulus.
// Expected results {diff, borrow, zero, ovf} are queued at the start
// handshake and checked by an independent monitor at each result handshake.
module tb_nibble_serial_sub_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sel = 1'b0;
  logic        start_valid = 1'b0;
  logic        diff_ready = 1'b1;
  logic [15:0] a_s = '0, b_s = '0;

  logic        sr4, dv4, br4, z4, o4;
  logic [15:0] d4;
  logic [1:0]  st4;
  logic        sr1, dv1, br1, z1, o1;
  logic [3:0]  d1;
  logic [1:0]  st1;

  int n_vec = 0;
  int n_err = 0;
  logic [18:0] exp_q[$];

  always #5 clk = ~clk;

  nibble_serial_sub_ctrl #(.NIBBLES(4)) u4 (
    .clk(clk), .rst_n(rst_n),
    .start_valid(start_valid && !sel), .start_ready(sr4),
    .a(a_s), .b(b_s),
    .diff_valid(dv4), .diff_ready(diff_ready),
    .diff(d4), .borrow(br4), .zero(z4), .ovf(o4), .state_dbg(st4)
  );

  nibble_serial_sub_ctrl #(.NIBBLES(1)) u1 (
    .clk(clk), .rst_n(rst_n),
    .start_valid(start_valid && sel), .start_ready(sr1),
    .a(a_s[3:0]), .b(b_s[3:0]),
    .diff_valid(dv1), .diff_ready(diff_ready),
    .diff(d1), .borrow(br1), .zero(z1), .ovf(o1), .state_dbg(st1)
  );

  logic        cur_sr, cur_valid;
  logic [18:0] cur_out;
  assign cur_sr    = sel ? sr1 : sr4;
  assign cur_valid = sel ? dv1 : dv4;
  assign cur_out   = sel ? {12'h000, d1, br1, z1, o1} : {d4, br4, z4, o4};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: got timeout expected event (t=%0t)", name, $time);
  endtask

  // Independent reference: plain subtraction on the masked operands.
  function automatic logic [18:0] model(input logic [15:0] ia, input logic [15:0] ib, input int nib);
    logic [15:0] mask, am, bm, d;
    logic br, z, ov;
    int w;
    w    = 4 * nib;
    mask = (nib == 4) ? 16'hFFFF : 16'h000F;
    am   = ia & mask;
    bm   = ib & mask;
    d    = (am - bm) & mask;
    br   = am < bm;
    z    = (d == 16'h0000);
    ov   = (am[w-1] != bm[w-1]) && (d[w-1] != am[w-1]);
    return {d, br, z, ov};
  endfunction

  // Monitor: one comparison per result handshake.
  always @(negedge clk) begin
    if (rst_n && cur_valid && diff_ready) begin
      if (exp_q.size() == 0) begin
        fail_now("unexpected_result");
      end else begin
        logic [18:0] e;
        e = exp_q.pop_front();
        check("result", {13'h0, cur_out}, {13'h0, e});
      end
    end
  end

  // Driver: one full operation, with optional backpressure and a stray
  // start_valid pulse while the block is busy.
  task automatic do_op(input logic [15:0] ia, input logic [15:0] ib,
                       input logic [18:0] exp, input int hold, input bit poke);
    int t;
    int lat;
    logic [18:0] snap;
    diff_ready = (hold == 0);
    t = 0;
    while (!cur_sr && t < 50) begin
      @(posedge clk); #1; t++;
    end
    if (!cur_sr) begin
      fail_now("start_ready_wait");
      return;
    end
    a_s = ia;
    b_s = ib;
    start_valid = 1'b1;
    @(posedge clk);
    exp_q.push_back(exp);
    #1 start_valid = 1'b0;
    lat = 0;
    while (lat < 50) begin
      if (poke && lat == 1) begin
        start_valid = 1'b1;
        a_s = 16'hFFFF;
        b_s = 16'h0000;
        check("start_ready_in_run", {31'h0, cur_sr}, 32'd0);
      end
      @(posedge clk); #1;
      start_valid = 1'b0;
      lat++;
      if (cur_valid) break;
    end
    check("latency", lat, sel ? 32'd1 : 32'd4);
    if (!cur_valid) return;
    snap = cur_out;
    repeat (hold) begin
      @(posedge clk); #1;
      check("hold_valid", {31'h0, cur_valid}, 32'd1);
      check("hold_stable", {13'h0, cur_out}, {13'h0, snap});
    end
    diff_ready = 1'b1;
    @(posedge clk); #1;
    check("start_ready_after", {31'h0, cur_sr}, 32'd1);
    check("valid_after", {31'h0, cur_valid}, 32'd0);
  endtask

  initial begin
    logic [15:0] ra, rb;
    int t;

    // Reset state (checked while rst_n is still low).
    repeat (2) @(posedge clk);
    #1;
    check("rst_start_ready", {31'h0, sr4}, 32'd1);
    check("rst_diff_valid", {31'h0, dv4}, 32'd0);
    check("rst_outputs", {13'h0, d4, br4, z4, o4}, 32'd0);
    check("rst_state", {30'h0, st4}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors, 16-bit instance.
    do_op(16'h1234, 16'h0234, {16'h1000, 1'b0, 1'b0, 1'b0}, 0, 1'b0);
    do_op(16'h1000, 16'h0001, {16'h0FFF, 1'b0, 1'b0, 1'b0}, 0, 1'b0);
    do_op(16'h0000, 16'h0001, {16'hFFFF, 1'b1, 1'b0, 1'b0}, 0, 1'b0);
    do_op(16'hA5A5, 16'hA5A5, {16'h0000, 1'b0, 1'b1, 1'b0}, 0, 1'b0);
    do_op(16'h8000, 16'h0001, {16'h7FFF, 1'b0, 1'b0, 1'b1}, 0, 1'b0);
    // Backpressure for 10 cycles in DONE.
    do_op(16'h7000, 16'h9000, {16'hE000, 1'b1, 1'b0, 1'b1}, 10, 1'b0);
    // Stray start_valid during RUN must not disturb the operation.
    do_op(16'h0010, 16'h0001, {16'h000F, 1'b0, 1'b0, 1'b0}, 0, 1'b1);

    // Reset during the 2nd RUN cycle; this operation is discarded.
    a_s = 16'h1234;
    b_s = 16'h0001;
    start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    @(posedge clk); #1;
    check("pre_reset_state_run", {30'h0, st4}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_start_ready", {31'h0, sr4}, 32'd1);
    check("mid_rst_diff_valid", {31'h0, dv4}, 32'd0);
    check("mid_rst_outputs", {13'h0, d4, br4, z4, o4}, 32'd0);
    check("mid_rst_state", {30'h0, st4}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    do_op(16'h0005, 16'h0003, {16'h0002, 1'b0, 1'b0, 1'b0}, 0, 1'b0);

    // Single-nibble instance.
    sel = 1'b1;
    do_op(16'h0004, 16'h0005, {16'h000F, 1'b1, 1'b0, 1'b0}, 0, 1'b0);
    do_op(16'h0008, 16'h0001, {16'h0007, 1'b0, 1'b0, 1'b1}, 3, 1'b0);
    do_op(16'h0003, 16'h0003, {16'h0000, 1'b0, 1'b1, 1'b0}, 0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      ra = 16'($urandom_range(0, 15));
      rb = 16'($urandom_range(0, 15));
      do_op(ra, rb, model(ra, rb, 1), 0, 1'b0);
    end

    // Random 16-bit operations.
    sel = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom_range(0, 65535));
      rb = 16'($urandom_range(0, 65535));
      do_op(ra, rb, model(ra, rb, 4), 0, 1'b0);
    end

    t = 0;
    while (exp_q.size() != 0 && t < 50) begin
      @(posedge clk); t++;
    end
    check("queue_drained", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
